ramd_fifo: RTL and testbench
============================

// Module: ramd_fifo
// PURPOSE
//  Parametrised synchronous FIFO built on dual-port distributed RAM (ramd32x1 class storage).
//  Generalises the 32x1 dual-port RAM primitive in width and depth.
//  Adds pointer management, occupancy count, programmable almost-full/almost-empty flags
//  and sticky overflow/underflow error flags.
//  Sits between datapath producers and consumers in the same clock domain.
// PARAMETERS
//  WIDTH     8   data width in bits (1..64)
//  AWIDTH    5   address width; DEPTH = 2**AWIDTH entries (5 -> 32, one ramd32x1 per bit)
//  AF_LEVEL  28  afull asserted when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  4   aempty asserted when count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  clk     in   1          single clock; all state changes on rising edge
//  mr      in   1          reset; synchronous, active-high
//  we      in   1          push request; d written when accepted
//  d       in   WIDTH      write data
//  re      in   1          pop request
//  q       out  WIDTH      read data, registered
//  full    out  1          count == DEPTH
//  empty   out  1          count == 0
//  afull   out  1          count >= AF_LEVEL
//  aempty  out  1          count <= AE_LEVEL
//  count   out  AWIDTH+1   current occupancy, 0..DEPTH
//  ovf     out  1          sticky: push attempted while full and not simultaneously popped
//  udf     out  1          sticky: pop attempted while empty
// BEHAVIOUR
//  - Reset (mr=1 at edge)
//    - wptr, rptr, count, q, ovf, udf <= 0.
//    - Resulting flags: empty=1, aempty=1, full=0, afull=0 (afull=1 only if AF_LEVEL==0, illegal).
//    - RAM contents are not cleared.
//    - mr has priority over we/re in the same cycle; a mid-operation reset discards all data.
//  - Acceptance, per cycle
//    - push_ok = we & (~full | re).
//    - pop_ok  = re & ~empty.
//    - Full with we&re: both accepted, count unchanged.
//    - Empty with we&re: push accepted, pop rejected, udf set.
//  - Push: mem[wptr] <= d; wptr <= wptr+1, wrapping mod DEPTH.
//  - Pop
//    - q <= mem[rptr] at the same edge; q valid the cycle after the pop (latency 1).
//    - rptr <= rptr+1, wrapping mod DEPTH.
//    - q holds its value when no pop is accepted.
//  - Count update
//    - count <= count + push_ok - pop_ok, evaluated in AWIDTH+1 bits; never wraps.
//    - All flags are combinational decodes of the registered count; they update the cycle after the access.
//  - Error flags
//    - ovf <= ovf | (we & full & ~re).
//    - udf <= udf | (re & empty).
//    - Both stick until mr.
//  - Read/write same address, same cycle: only when count==0 (pop rejected) or count==DEPTH (pop reads old data).
//    No read-during-write hazard is visible at q.
//  - No state machine beyond pointers and count; the block holds no handshake state.
// STRUCTURE
//  - Shared include dy_fifo_defs.vh
//    - Default WIDTH/AWIDTH.
//    - Macro for the count width (AWIDTH+1).
//  - Sub-module ramd_fifo_mem(clk, we, wa, d, ra, r)
//    - WIDTH x DEPTH dual-port RAM: synchronous write, asynchronous read.
//    - Maps onto WIDTH ramd32x1 instances when AWIDTH==5; behavioural array otherwise.
//  - Top level holds pointers, count, flags and the q register.
// TESTING
//  1. Assert mr for 2 cycles mid-stream after 10 pushes -> count=0, empty=1, q=0, ovf=udf=0;
//     next pop sets udf.
//  2. Push 0x01..0x20 (32 words, defaults) -> full=1, afull=1 after push 28 (count=28);
//     pop all -> q sequence 0x01..0x20 each one cycle after re; empty=1 at end.
//  3. With full, assert we&re for 5 cycles with d=0xA0.. -> count stays 32, no ovf;
//     order preserved across pointer wrap.
//  4. Push while full (re=0) -> ovf=1, count=32, data unchanged;
//     pop while empty -> udf=1, q unchanged; both stay set until mr.
//  5. Empty FIFO, we&re with d=0x55 -> count=1, udf=1, q unchanged;
//     next pop gives q=0x55.
//  6. WIDTH=16, AWIDTH=3, AF_LEVEL=6, AE_LEVEL=1
//     -> afull at count 6, aempty at count<=1, full at 8; wrap after 8 pushes.

Source files
------------

// File: rtl/ramd_fifo_pkg.sv
// Shared defaults for the distributed-RAM FIFO.
// Holds the default data/address widths, the default flag thresholds and
// a helper that gives the width of the occupancy counter (AWIDTH+1 bits,
// so that a completely full FIFO can be told apart from an empty one).
package ramd_fifo_pkg;

  localparam int FIFO_WIDTH_DEF  = 8;
  localparam int FIFO_AWIDTH_DEF = 5;
  localparam int FIFO_AF_DEF     = 28;
  localparam int FIFO_AE_DEF     = 4;

  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/ramd_fifo_mem.sv
// WIDTH x 2**AWIDTH dual-port storage: synchronous write, asynchronous read.
// Written as a plain array so synthesis maps it onto distributed RAM; with
// AWIDTH==5 each data bit lands in one 32x1 dual-port cell.
// Ports:
//   clk  write clock
//   we   write enable
//   wa   write address
//   d    write data
//   ra   read address
//   r    read data, combinational from ra
module ramd_fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] wa,
  input  logic [WIDTH-1:0]  d,
  input  logic [AWIDTH-1:0] ra,
  output logic [WIDTH-1:0]  r
);

  localparam int DEPTH = 1 << AWIDTH;

  // Contents are deliberately never cleared; reset only touches the pointers.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= d;
  end

  assign r = mem[ra];

endmodule

// File: rtl/ramd_fifo.sv
// Synchronous FIFO on dual-port distributed RAM.
// Keeps read/write pointers, the occupancy count, the registered read data,
// programmable almost-full/almost-empty flags and sticky overflow/underflow.
// Ports:
//   clk     clock, all state changes on the rising edge
//   mr      synchronous active-high reset, wins over we/re
//   we, d   push request and write data
//   re      pop request
//   q       registered read data, valid the cycle after an accepted pop
//   full, empty, afull, aempty   decodes of the registered count
//   count   occupancy 0..DEPTH
//   ovf     sticky: push while full without a simultaneous pop
//   udf     sticky: pop while empty
module ramd_fifo
  import ramd_fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH_DEF,
  parameter int AWIDTH   = FIFO_AWIDTH_DEF,
  parameter int AF_LEVEL = FIFO_AF_DEF,
  parameter int AE_LEVEL = FIFO_AE_DEF
) (
  input  logic              clk,
  input  logic              mr,
  input  logic              we,
  input  logic [WIDTH-1:0]  d,
  input  logic              re,
  output logic [WIDTH-1:0]  q,
  output logic              full,
  output logic              empty,
  output logic              afull,
  output logic              aempty,
  output logic [AWIDTH:0]   count,
  output logic              ovf,
  output logic              udf
);

  localparam int CW = cnt_width(AWIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(1 << AWIDTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [AWIDTH-1:0] wptr, rptr;
  logic [WIDTH-1:0]  rdata;
  logic              push_ok, pop_ok;

  // A push into a full FIFO is still fine when a pop frees the slot in the
  // same cycle; the async read returns the old word before it is overwritten.
  assign push_ok = we & (~full | re);
  assign pop_ok  = re & ~empty;

  assign full   = (count == DEPTH_C);
  assign empty  = (count == '0);
  assign afull  = (count >= AF_C);
  assign aempty = (count <= AE_C);

  ramd_fifo_mem #(
    .WIDTH  (WIDTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .clk (clk),
    .we  (push_ok),
    .wa  (wptr),
    .d   (d),
    .ra  (rptr),
    .r   (rdata)
  );

  always_ff @(posedge clk) begin
    if (mr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      q     <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok) begin
        rptr <= rptr + 1'b1;
        q    <= rdata;
      end
      count <= count + CW'(push_ok) - CW'(pop_ok);
      ovf   <= ovf | (we & full & ~re);
      udf   <= udf | (re & empty);
    end
  end

endmodule

// File: tb/tb_ramd_fifo.sv
module tb_ramd_fifo;

  logic        clk = 1'b0;
  logic        mr = 1'b0, we = 1'b0, re = 1'b0;
  logic [7:0]  d = '0;
  logic [7:0]  q;
  logic        full, empty, afull, aempty, ovf, udf;
  logic [5:0]  count;

  logic        mr_b = 1'b0, we_b = 1'b0, re_b = 1'b0;
  logic [15:0] d_b = '0;
  logic [15:0] q_b;
  logic        full_b, empty_b, afull_b, aempty_b, ovf_b, udf_b;
  logic [3:0]  count_b;

  always #5 clk = ~clk;

  ramd_fifo dut (
    .clk(clk), .mr(mr), .we(we), .d(d), .re(re), .q(q),
    .full(full), .empty(empty), .afull(afull), .aempty(aempty),
    .count(count), .ovf(ovf), .udf(udf)
  );

  ramd_fifo #(.WIDTH(16), .AWIDTH(3), .AF_LEVEL(6), .AE_LEVEL(1)) dut_b (
    .clk(clk), .mr(mr_b), .we(we_b), .d(d_b), .re(re_b), .q(q_b),
    .full(full_b), .empty(empty_b), .afull(afull_b), .aempty(aempty_b),
    .count(count_b), .ovf(ovf_b), .udf(udf_b)
  );

  int npass = 0;
  int ntotal = 0;

  // reference model for the default instance
  logic [7:0] mdata[$];
  logic [7:0] sb[$];
  int         m_cnt = 0;
  logic [7:0] m_q = '0;
  logic       m_ovf = 1'b0, m_udf = 1'b0;

  // reference model for the 16x8 instance
  logic [15:0] mdata_b[$];
  logic [15:0] sb_b[$];
  int          mb_cnt = 0;
  logic [15:0] mb_q = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      npass++;
  endtask

  task automatic check_status();
    chk("q", 32'(q), 32'(m_q));
    chk("status {count,full,empty,afull,aempty,ovf,udf}",
        32'({count, full, empty, afull, aempty, ovf, udf}),
        32'({6'(m_cnt), m_cnt == 32, m_cnt == 0, m_cnt >= 28, m_cnt <= 4, m_ovf, m_udf}));
  endtask

  task automatic cycle(input logic w, input logic r, input logic [7:0] dd);
    logic push_ok, pop_ok;
    we = w; re = r; d = dd;
    push_ok = w && (m_cnt != 32 || r);
    pop_ok  = r && (m_cnt != 0);
    if (w && m_cnt == 32 && !r) m_ovf = 1'b1;
    if (r && m_cnt == 0) m_udf = 1'b1;
    if (pop_ok) sb.push_back(mdata.pop_front());
    if (push_ok) mdata.push_back(dd);
    m_cnt = m_cnt + int'(push_ok) - int'(pop_ok);
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
    if (sb.size() > 0) m_q = sb.pop_front();
    check_status();
  endtask

  task automatic do_reset(input int n, input logic w);
    mr = 1'b1; we = w; re = 1'b0; d = 8'hEE;
    repeat (n) @(posedge clk);
    #1;
    mr = 1'b0; we = 1'b0;
    mdata.delete(); sb.delete();
    m_cnt = 0; m_q = '0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic cycle_b(input logic w, input logic r, input logic [15:0] dd);
    logic push_ok, pop_ok;
    we_b = w; re_b = r; d_b = dd;
    push_ok = w && (mb_cnt != 8 || r);
    pop_ok  = r && (mb_cnt != 0);
    if (pop_ok) sb_b.push_back(mdata_b.pop_front());
    if (push_ok) mdata_b.push_back(dd);
    mb_cnt = mb_cnt + int'(push_ok) - int'(pop_ok);
    @(posedge clk); #1;
    we_b = 1'b0; re_b = 1'b0;
    if (sb_b.size() > 0) mb_q = sb_b.pop_front();
    chk("b.q", 32'(q_b), 32'(mb_q));
    chk("b.status {count,full,empty,afull,aempty}",
        32'({count_b, full_b, empty_b, afull_b, aempty_b}),
        32'({4'(mb_cnt), mb_cnt == 8, mb_cnt == 0, mb_cnt >= 6, mb_cnt <= 1}));
  endtask

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] dd;
    int         cnt;
    logic [7:0] eq;
    logic       eu;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{w:1'b0, r:1'b1, dd:8'h00, cnt:0, eq:8'h00, eu:1'b1};
    tbl[1] = '{w:1'b1, r:1'b1, dd:8'h55, cnt:1, eq:8'h00, eu:1'b1};
    tbl[2] = '{w:1'b0, r:1'b1, dd:8'h00, cnt:0, eq:8'h55, eu:1'b1};
    tbl[3] = '{w:1'b1, r:1'b0, dd:8'h66, cnt:1, eq:8'h55, eu:1'b1};
    tbl[4] = '{w:1'b1, r:1'b0, dd:8'h77, cnt:2, eq:8'h55, eu:1'b1};
    tbl[5] = '{w:1'b0, r:1'b1, dd:8'h00, cnt:1, eq:8'h66, eu:1'b1};
    tbl[6] = '{w:1'b1, r:1'b1, dd:8'h88, cnt:1, eq:8'h77, eu:1'b1};
    tbl[7] = '{w:1'b0, r:1'b1, dd:8'h00, cnt:0, eq:8'h88, eu:1'b1};

    mr_b = 1'b1;
    do_reset(2, 1'b0);
    mr_b = 1'b0;
    check_status();

    // mid-stream reset discards data, wins over a concurrent push
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(i + 1));
    cycle(1'b0, 1'b1, 8'h00);
    do_reset(2, 1'b1);
    chk("reset count", 32'(count), 32'd0);
    chk("reset empty", 32'(empty), 32'd1);
    chk("reset q", 32'(q), 32'd0);
    chk("reset ovf/udf", 32'({ovf, udf}), 32'd0);
    cycle(1'b0, 1'b1, 8'h00);
    chk("udf after reset pop", 32'(udf), 32'd1);

    // table: empty-FIFO simultaneous push/pop and latency-1 reads
    do_reset(1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].w, tbl[i].r, tbl[i].dd);
      chk("tbl count", 32'(count), 32'(tbl[i].cnt));
      chk("tbl q", 32'(q), 32'(tbl[i].eq));
      chk("tbl udf", 32'(udf), 32'(tbl[i].eu));
    end

    // fill 0x01..0x20, almost-full boundary, drain in order
    do_reset(1, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      cycle(1'b1, 1'b0, 8'(i));
      if (i == 27) chk("afull at 27", 32'(afull), 32'd0);
      if (i == 28) chk("afull at 28", 32'(afull), 32'd1);
      if (i == 31) chk("full at 31", 32'(full), 32'd0);
    end
    chk("full at 32", 32'(full), 32'd1);
    for (int i = 1; i <= 32; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      chk("drain q", 32'(q), 32'(i));
    end
    chk("empty after drain", 32'(empty), 32'd1);

    // full with we&re across pointer wrap
    for (int i = 1; i <= 32; i++) cycle(1'b1, 1'b0, 8'(i));
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b1, 8'hA0 + 8'(k));
      chk("full we&re count", 32'(count), 32'd32);
      chk("full we&re q", 32'(q), 32'(k + 1));
    end
    chk("no ovf on we&re", 32'(ovf), 32'd0);
    for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 8'h00);
    chk("last after wrap", 32'(q), 32'hA4);

    // overflow/underflow stickiness
    do_reset(1, 1'b0);
    for (int i = 1; i <= 32; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i));
    cycle(1'b1, 1'b0, 8'hFF);
    chk("ovf set", 32'(ovf), 32'd1);
    chk("ovf count", 32'(count), 32'd32);
    for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 8'h00);
    chk("data unchanged by ovf", 32'(q), 32'h60);
    cycle(1'b0, 1'b1, 8'h00);
    chk("udf set", 32'(udf), 32'd1);
    chk("q held on udf", 32'(q), 32'h60);
    repeat (3) cycle(1'b0, 1'b0, 8'h00);
    chk("sticky ovf/udf", 32'({ovf, udf}), 32'h3);
    do_reset(1, 1'b0);
    chk("ovf/udf cleared", 32'({ovf, udf}), 32'h0);

    // small configuration: 16 bits x 8 entries
    for (int i = 1; i <= 8; i++) cycle_b(1'b1, 1'b0, 16'h1000 + 16'(i));
    cycle_b(1'b0, 1'b1, 16'h0);
    cycle_b(1'b1, 1'b0, 16'hBEEF);
    for (int i = 0; i < 8; i++) cycle_b(1'b0, 1'b1, 16'h0);
    chk("b.wrap last", 32'(q_b), 32'hBEEF);
    for (int i = 0; i < 3; i++) cycle_b(1'b1, 1'b1, 16'h2000 + 16'(i));
    cycle_b(1'b0, 1'b1, 16'h0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
